// File: rtl/post_adder_acc.sv
// Post-adder/accumulator stage of a DSP48A1-style slice: OPMODE-selected X/Z muxes,
// 48-bit add/subtract with carry-in, P and carry-out registers, cascade outputs.
module post_adder_acc #(
  parameter int    PREG        = 1,
  parameter int    CARRYINREG  = 1,
  parameter int    CARRYOUTREG = 1,
  parameter string CARRYINSEL  = "OPMODE5"
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cep,
  input  logic        cecarryin,
  input  logic [7:0]  opmode,
  input  logic [35:0] m,
  input  logic [47:0] dab,
  input  logic [47:0] c,
  input  logic [47:0] pcin,
  input  logic        carryin,
  output logic [47:0] p,
  output logic [47:0] pcout,
  output logic        carryout,
  output logic        carryoutf
);

  logic [47:0] p_q, p_d;
  logic        co_q, co_d;
  logic        cin_q, cin_d;

  logic        cin_src;
  logic        cin_used;
  logic [47:0] p_fb;
  logic [47:0] m_ext;
  logic [47:0] x_mux;
  logic [47:0] z_mux;
  logic [48:0] sum;
  logic        unused_opmode;

  assign unused_opmode = opmode[6] ^ opmode[4];

  assign m_ext = {{12{m[35]}}, m};

  // Without a P register, feedback reads zero so no combinational loop forms.
  assign p_fb = (PREG != 0) ? p_q : 48'd0;

  always_comb begin
    cin_src = (CARRYINSEL == "CARRYIN") ? carryin : opmode[5];
    cin_used = (CARRYINREG != 0) ? cin_q : cin_src;

    x_mux = 48'd0;
    unique case (opmode[1:0])
      2'd0: x_mux = 48'd0;
      2'd1: x_mux = m_ext;
      2'd2: x_mux = p_fb;
      2'd3: x_mux = dab;
      default: x_mux = 48'd0;
    endcase

    z_mux = 48'd0;
    unique case (opmode[3:2])
      2'd0: z_mux = 48'd0;
      2'd1: z_mux = pcin;
      2'd2: z_mux = p_fb;
      2'd3: z_mux = c;
      default: z_mux = 48'd0;
    endcase

    // Bit 48 is the carry on add and the borrow on subtract.
    if (opmode[7])
      sum = {1'b0, z_mux} - ({1'b0, x_mux} + {48'd0, cin_used});
    else
      sum = {1'b0, z_mux} + {1'b0, x_mux} + {48'd0, cin_used};

    p_d   = cep ? sum[47:0] : p_q;
    co_d  = cep ? sum[48] : co_q;
    cin_d = cecarryin ? cin_src : cin_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      p_q   <= 48'd0;
      co_q  <= 1'b0;
      cin_q <= 1'b0;
    end else begin
      p_q   <= p_d;
      co_q  <= co_d;
      cin_q <= cin_d;
    end
  end

  assign p         = (PREG != 0) ? p_q : sum[47:0];
  assign carryout  = (CARRYOUTREG != 0) ? co_q : sum[48];
  assign pcout     = p;
  assign carryoutf = carryout;

endmodule

// File: tb/tb_post_adder_acc.sv
// Bench for post_adder_acc: table of registered-path vectors on a default instance,
// plus hand sequences on a fully combinational instance using the carryin port.
module tb_post_adder_acc;

  logic        clk = 1'b0;
  logic        rst, cep, cecarryin, carryin;
  logic [7:0]  opmode;
  logic [35:0] m;
  logic [47:0] dab, c, pcin;

  logic [47:0] p, pcout, p0, pcout0;
  logic        carryout, carryoutf, carryout0, carryoutf0;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  post_adder_acc dut (
    .clk(clk), .rst(rst), .cep(cep), .cecarryin(cecarryin), .opmode(opmode),
    .m(m), .dab(dab), .c(c), .pcin(pcin), .carryin(carryin),
    .p(p), .pcout(pcout), .carryout(carryout), .carryoutf(carryoutf)
  );

  post_adder_acc #(
    .PREG(0), .CARRYINREG(0), .CARRYOUTREG(0), .CARRYINSEL("CARRYIN")
  ) dut0 (
    .clk(clk), .rst(rst), .cep(cep), .cecarryin(cecarryin), .opmode(opmode),
    .m(m), .dab(dab), .c(c), .pcin(pcin), .carryin(carryin),
    .p(p0), .pcout(pcout0), .carryout(carryout0), .carryoutf(carryoutf0)
  );

  typedef struct {
    logic        rst;
    logic        cep;
    logic [7:0]  op;
    logic [35:0] m;
    logic [47:0] dab;
    logic [47:0] c;
    logic [47:0] pcin;
    logic [47:0] ep;
    logic        eco;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(logic r, logic e, logic [7:0] op, logic [35:0] mm,
                              logic [47:0] d, logic [47:0] cc, logic [47:0] pc,
                              logic [47:0] ep, logic eco);
    vec_t v;
    v.rst = r; v.cep = e; v.op = op; v.m = mm; v.dab = d; v.c = cc; v.pcin = pc;
    v.ep = ep; v.eco = eco;
    return v;
  endfunction

  task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  localparam logic [35:0] M_NEG2 = 36'hF_FFFF_FFFE;

  initial begin
    rst = 1'b1; cep = 1'b1; cecarryin = 1'b1; carryin = 1'b0;
    opmode = 8'h00; m = '0; dab = '0; c = '0; pcin = '0;

    // Carry-in register holds opmode[5] of the previous row (cecarryin=1 throughout).
    //                rst  cep  op     m        dab      c                   pcin   exp p                 co
    vt.push_back(mk(1'b1, 1'b1, 8'h2D, 36'd5,   48'd0,   48'd10,             48'd0, 48'd0,                1'b0));
    vt.push_back(mk(1'b1, 1'b1, 8'h0F, 36'd0,   48'd123, 48'd77,             48'd0, 48'd0,                1'b0));
    vt.push_back(mk(1'b0, 1'b0, 8'h2D, 36'd5,   48'd0,   48'd10,             48'd0, 48'd0,                1'b0));
    vt.push_back(mk(1'b0, 1'b1, 8'h2D, 36'd5,   48'd0,   48'd10,             48'd0, 48'd16,               1'b0));
    vt.push_back(mk(1'b0, 1'b0, 8'h8D, 36'd5,   48'd0,   48'd3,              48'd0, 48'd16,               1'b0));
    vt.push_back(mk(1'b0, 1'b1, 8'h8D, 36'd5,   48'd0,   48'd3,              48'd0, 48'hFFFF_FFFF_FFFE,   1'b1));
    vt.push_back(mk(1'b1, 1'b1, 8'h09, M_NEG2,  48'd0,   48'd0,              48'd0, 48'd0,                1'b0));
    vt.push_back(mk(1'b0, 1'b1, 8'h09, M_NEG2,  48'd0,   48'd0,              48'd0, 48'hFFFF_FFFF_FFFE,   1'b0));
    vt.push_back(mk(1'b0, 1'b1, 8'h09, M_NEG2,  48'd0,   48'd0,              48'd0, 48'hFFFF_FFFF_FFFC,   1'b1));
    vt.push_back(mk(1'b0, 1'b1, 8'h09, M_NEG2,  48'd0,   48'd0,              48'd0, 48'hFFFF_FFFF_FFFA,   1'b1));
    vt.push_back(mk(1'b0, 1'b1, 8'h09, M_NEG2,  48'd0,   48'd0,              48'd0, 48'hFFFF_FFFF_FFF8,   1'b1));
    vt.push_back(mk(1'b0, 1'b0, 8'h09, M_NEG2,  48'd0,   48'd0,              48'd0, 48'hFFFF_FFFF_FFF8,   1'b1));
    vt.push_back(mk(1'b0, 1'b0, 8'h09, M_NEG2,  48'd0,   48'd0,              48'd0, 48'hFFFF_FFFF_FFF8,   1'b1));
    vt.push_back(mk(1'b1, 1'b1, 8'h09, M_NEG2,  48'd0,   48'd0,              48'd0, 48'd0,                1'b0));
    vt.push_back(mk(1'b0, 1'b1, 8'h09, M_NEG2,  48'd0,   48'd0,              48'd0, 48'hFFFF_FFFF_FFFE,   1'b0));
    vt.push_back(mk(1'b0, 1'b1, 8'h0F, 36'd0,   48'd0,   48'hFFFF_FFFF_FFFF, 48'd0, 48'hFFFF_FFFF_FFFF,   1'b0));
    vt.push_back(mk(1'b0, 1'b1, 8'h0B, 36'd0,   48'd1,   48'd0,              48'd0, 48'd0,                1'b1));
    vt.push_back(mk(1'b0, 1'b1, 8'h8F, 36'd0,   48'd100, 48'd300,            48'd0, 48'd200,              1'b0));
    vt.push_back(mk(1'b0, 1'b0, 8'hAF, 36'd0,   48'd100, 48'd300,            48'd0, 48'd200,              1'b0));
    vt.push_back(mk(1'b0, 1'b1, 8'hAF, 36'd0,   48'd100, 48'd300,            48'd0, 48'd199,              1'b0));
    vt.push_back(mk(1'b0, 1'b1, 8'h84, 36'd0,   48'd0,   48'd0,              48'd50, 48'd49,              1'b0));

    for (int i = 0; i < vt.size(); i++) begin
      rst = vt[i].rst; cep = vt[i].cep; opmode = vt[i].op; m = vt[i].m;
      dab = vt[i].dab; c = vt[i].c; pcin = vt[i].pcin;
      @(posedge clk);
      #1;
      chk($sformatf("row%0d p", i), p, vt[i].ep);
      chk($sformatf("row%0d carryout", i), {47'd0, carryout}, {47'd0, vt[i].eco});
      chk($sformatf("row%0d pcout", i), pcout, vt[i].ep);
      chk($sformatf("row%0d carryoutf", i), {47'd0, carryoutf}, {47'd0, vt[i].eco});
    end

    // Combinational instance: feedback reads zero, carry-in comes from the port.
    rst = 1'b0; cep = 1'b1; carryin = 1'b0; opmode = 8'h09; m = 36'd7;
    dab = '0; c = '0; pcin = '0;
    #1;
    chk("preg0 feedback p", p0, 48'd7);
    chk("preg0 feedback pcout", pcout0, 48'd7);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("preg0 rst ignored", p0, 48'd7);
    rst = 1'b0; carryin = 1'b1;
    #1;
    chk("preg0 carryin port", p0, 48'd8);
    carryin = 1'b0; opmode = 8'h2D; m = 36'd5; c = 48'd10;
    #1;
    chk("preg0 opmode5 ignored", p0, 48'd15);
    opmode = 8'h8D; c = 48'd3;
    #1;
    chk("preg0 sub p", p0, 48'hFFFF_FFFF_FFFE);
    chk("preg0 sub carryout", {47'd0, carryout0}, 48'd1);
    chk("preg0 sub carryoutf", {47'd0, carryoutf0}, 48'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/post_adder_acc.md
# post_adder_acc

Post-adder/accumulator stage of the DSP48A1 slice. Consumes the registered 36-bit multiplier product and the D:A:B, C and PCIN operands produced by the upstream pipeline registers. Combines them through OPMODE-controlled X/Z multiplexers into a 48-bit add/subtract with carry-in. Drives the P register, the carry-out register and the cascade outputs, and supports P feedback for multiply-accumulate.

## Interface
- `PREG`, default 1: 1 = P output registered; 0 = combinational (P feedback selections read as zero).
- `CARRYINREG`, default 1: 1 = carry-in registered in the stage parallel to the upstream M register; 0 = passthrough.
- `CARRYOUTREG`, default 1: 1 = carry-out registered; 0 = combinational.
- `CARRYINSEL`, default "OPMODE5": "OPMODE5" selects `opmode[5]` as carry-in; "CARRYIN" selects the `carryin` port.
- `clk`, input, 1: single clock; all registers update on the rising edge.
- `rst`, input, 1: synchronous, active-high reset. Clears P, the carry-in register and the carry-out register on the next rising edge; has priority over the enables.
- `cep`, input, 1: clock enable for the P and carry-out registers.
- `cecarryin`, input, 1: clock enable for the carry-in register.
- `opmode`, input, 8: [1:0] X select, [3:2] Z select, [5] carry-in value, [7] subtract. Bits [4] and [6] are ignored here.
- `m`, input, 36: registered product; sign-extended to 48 bits.
- `dab`, input, 48: concatenation {D[11:0], A[17:0], B[17:0]}.
- `c`, input, 48: C operand.
- `pcin`, input, 48: cascade input from the previous slice.
- `carryin`, input, 1: external carry-in.
- `p`, output, 48: result.
- `pcout`, output, 48: identical to `p`.
- `carryout`, output, 1: carry/borrow out.
- `carryoutf`, output, 1: identical to `carryout` (fabric copy).

## Operation
- X multiplexer by `opmode[1:0]`:
  - 0 → 0
  - 1 → sign-extended `m`
  - 2 → `p` (registered value)
  - 3 → `dab`
- Z multiplexer by `opmode[3:2]`:
  - 0 → 0
  - 1 → `pcin`
  - 2 → `p` (registered value)
  - 3 → `c`
- When PREG=0, selecting `p` on X or Z yields 0. No combinational loop is permitted.
- Carry-in source CIN: `opmode[5]` or `carryin` per CARRYINSEL. Any other CARRYINSEL string behaves as "OPMODE5".
- Add, `opmode[7]`=0: {co, r} = {1'b0,Z} + {1'b0,X} + CIN. This is 49-bit arithmetic, modulo 2^48 on r.
- Subtract, `opmode[7]`=1: {co, r} = {1'b0,Z} − ({1'b0,X} + CIN). co=1 indicates a borrow (Z < X+CIN).
- P register: `rst` → 0; else if `cep` → r; else hold. Carry-out register follows the same rule with co.
- Carry-in register: `rst` → 0; else if `cecarryin` → CIN; else hold. The registered value is the one used by the adder.
- Accumulate: X=`m`, Z=`p`. Each enabled cycle adds the product to the running P. P wraps modulo 2^48 with no saturation; overflow is only reflected in `carryout`.
- `pcout` and `carryoutf` are pure wires from `p` and `carryout`.

## Timing
- Reset values: `p`=0, `pcout`=0, `carryout`=0, `carryoutf`=0. Registered paths take these values on the first rising edge with `rst`=1.
- Latency, PREG=1: r is visible on `p` 1 cycle after the operands and `opmode` are presented.
- Latency, PREG=0: r is visible on `p` in the same cycle.
- With CARRYINREG=1, CIN must be presented one cycle earlier than `m`, aligned with the upstream multiplier inputs.
- `rst` and `cep` asserted in the same cycle: reset wins.
- `rst` mid-accumulation: P becomes 0 at that edge. The next enabled edge adds to 0, not to the pre-reset value.
- `cep`=0 freezes P and carryout. Feedback keeps reading the frozen P.
- `opmode` changes take effect on the very next edge; there is no pipelining of `opmode` inside this block.

## Test plan
- Reset: drive arbitrary operands with `cep`=1 and `rst`=1 → `p`=0 and `carryout`=0 after 1 edge; values hold while `rst` stays high.
- Add with carry: `opmode`=0x2D (X=m, Z=c, CIN=1), `m`=5, `c`=10 → `p`=16 one cycle later; carry-in register primed one cycle earlier.
- Subtract borrow: `opmode`=0x8D with CIN=0, `c`=3, `m`=5 → `p`=0xFFFF_FFFF_FFFE and `carryout`=1.
- Accumulate: `opmode`=0x09 (X=m, Z=p), `m`=−2 (36'hF_FFFF_FFFE), 4 enabled cycles from P=0 → `p` steps through −2, −4, −6, −8; then `cep`=0 for 2 cycles holds −8.
- Wrap: P=48'hFFFF_FFFF_FFFF, X=`dab`=1, Z=`p`, CIN=0 → `p`=0 and `carryout`=1; `pcout`/`carryoutf` mirror these values.
- PREG=0 instance: selecting Z=`p` with X=`m`=7 → `p`=7 combinationally (feedback reads 0); `rst` has no effect on `p`.
